// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, control bundle,
// the ID/EX payload layout and the opcode classifier used by decode_stage.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic reg_write;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t     ctrl;
    imm_type_e imm_type;
    logic      use_rs1;
    logic      use_rs2;
  } decode_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [5:0]      rs1;
    logic [5:0]      rs2;
    logic [5:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    ctrl_t           ctrl;
  } id_ex_t;

  // Every legal opcode ends in 2'b11, so a bad instr[1:0] lands in the default arm.
  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t d;
    d          = '0;
    d.imm_type = IMM_NONE;
    d.use_rs1  = 1'b1;
    case (instr[6:0])
      OP: begin
        d.ctrl.reg_write = 1'b1;
        d.use_rs2        = 1'b1;
      end
      OP_IMM, JALR: begin
        d.ctrl.reg_write = 1'b1;
        d.imm_type       = IMM_I;
      end
      LOAD: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.is_load   = 1'b1;
        d.imm_type       = IMM_I;
      end
      STORE: begin
        d.ctrl.is_store = 1'b1;
        d.imm_type      = IMM_S;
        d.use_rs2       = 1'b1;
      end
      BRANCH: begin
        d.ctrl.is_branch = 1'b1;
        d.imm_type       = IMM_B;
        d.use_rs2        = 1'b1;
      end
      LUI, AUIPC: begin
        d.ctrl.reg_write = 1'b1;
        d.imm_type       = IMM_U;
        d.use_rs1        = 1'b0;
      end
      JAL: begin
        d.ctrl.reg_write = 1'b1;
        d.imm_type       = IMM_J;
        d.use_rs1        = 1'b0;
      end
      default: d.ctrl.illegal = 1'b1;
    endcase
    if (instr[11:7] == 5'd0) d.ctrl.reg_write = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF->ID and ID->EX pipeline handshake and payload. The slave modport is the
// decode stage; the master modport is the surrounding pipeline (IF and EX).
interface decode_stage_if;
  import rv_pkg::*;

  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [5:0]      ex_rs1;
  logic [5:0]      ex_rs2;
  logic [5:0]      ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic            ex_reg_write;
  logic            ex_is_load;
  logic            ex_is_store;
  logic            ex_is_branch;
  logic            ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7,
           ex_reg_write, ex_is_load, ex_is_store, ex_is_branch, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7,
           ex_reg_write, ex_is_load, ex_is_store, ex_is_branch, ex_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: reassembles the I/S/B/U/J immediate fields and
// sign-extends from instr[31]; register-register ops yield zero.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  // NOTE: assigning a default before the case keeps this purely combinational;
  // a path that leaves imm unassigned would infer a latch.
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file addressing, ID/EX register, load-use stall
// and writeback/read collision. Define DECODE_WB_BYPASS_EN to bypass the
// writeback value instead of stalling on a collision.
module decode_stage
  import rv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  decode_stage_if.slave    pipe,
  output logic [5:0]       rf_read_reg1,
  output logic [5:0]       rf_read_reg2,
  input  logic [XLEN-1:0]  rf_read_data1,
  input  logic [XLEN-1:0]  rf_read_data2,
  input  logic             wb_write_enable,
  input  logic [5:0]       wb_write_reg,
  input  logic [XLEN-1:0]  wb_write_data,
  input  logic             flush
);

  logic [4:0]      rs1, rs2, rd;
  decode_t         dec;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op1, op2;
  logic            wb_hit1, wb_hit2;
  logic            load_use, hazard, capture;
  logic            ex_valid_q;
  id_ex_t          id_ex_q, id_ex_d;

  assign rs1 = pipe.if_instr[19:15];
  assign rs2 = pipe.if_instr[24:20];
  assign rd  = pipe.if_instr[11:7];
  assign dec = decode_instr(pipe.if_instr);

  assign rf_read_reg1 = {1'b0, rs1};
  assign rf_read_reg2 = {1'b0, rs2};

  imm_gen u_imm_gen (
    .instr    (pipe.if_instr),
    .imm_type (dec.imm_type),
    .imm      (imm)
  );

  // The register file returns the old value while it is being written.
  assign wb_hit1 = wb_write_enable & (wb_write_reg == {1'b0, rs1}) & (rs1 != 5'd0);
  assign wb_hit2 = wb_write_enable & (wb_write_reg == {1'b0, rs2}) & (rs2 != 5'd0);

  assign load_use = ex_valid_q & id_ex_q.ctrl.is_load & (id_ex_q.rd != 6'd0) &
                    ((dec.use_rs1 & (id_ex_q.rd == {1'b0, rs1})) |
                     (dec.use_rs2 & (id_ex_q.rd == {1'b0, rs2})));

`ifdef DECODE_WB_BYPASS_EN
  assign hazard = load_use;
  assign op1    = (rs1 == 5'd0) ? '0 : (wb_hit1 ? wb_write_data : rf_read_data1);
  assign op2    = (rs2 == 5'd0) ? '0 : (wb_hit2 ? wb_write_data : rf_read_data2);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_write_data;
  assign hazard = load_use | (dec.use_rs1 & wb_hit1) | (dec.use_rs2 & wb_hit2);
  assign op1    = (rs1 == 5'd0) ? '0 : rf_read_data1;
  assign op2    = (rs2 == 5'd0) ? '0 : rf_read_data2;
`endif

  assign pipe.if_ready = (~ex_valid_q | pipe.ex_ready) & ~hazard & ~flush & ~reset;
  assign capture       = pipe.if_valid & pipe.if_ready;

  always_comb begin
    id_ex_d          = '0;
    id_ex_d.pc       = pipe.if_pc;
    id_ex_d.rs1_data = op1;
    id_ex_d.rs2_data = op2;
    id_ex_d.imm      = imm;
    id_ex_d.rs1      = {1'b0, rs1};
    id_ex_d.rs2      = {1'b0, rs2};
    id_ex_d.rd       = {1'b0, rd};
    id_ex_d.opcode   = pipe.if_instr[6:0];
    id_ex_d.funct3   = pipe.if_instr[14:12];
    id_ex_d.funct7   = pipe.if_instr[31:25];
    id_ex_d.ctrl     = dec.ctrl;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      id_ex_q    <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (capture) begin
      ex_valid_q <= 1'b1;
      id_ex_q    <= id_ex_d;
    end else if (pipe.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign pipe.ex_valid     = ex_valid_q;
  assign pipe.ex_pc        = id_ex_q.pc;
  assign pipe.ex_rs1_data  = id_ex_q.rs1_data;
  assign pipe.ex_rs2_data  = id_ex_q.rs2_data;
  assign pipe.ex_imm       = id_ex_q.imm;
  assign pipe.ex_rs1       = id_ex_q.rs1;
  assign pipe.ex_rs2       = id_ex_q.rs2;
  assign pipe.ex_rd        = id_ex_q.rd;
  assign pipe.ex_opcode    = id_ex_q.opcode;
  assign pipe.ex_funct3    = id_ex_q.funct3;
  assign pipe.ex_funct7    = id_ex_q.funct7;
  assign pipe.ex_reg_write = id_ex_q.ctrl.reg_write;
  assign pipe.ex_is_load   = id_ex_q.ctrl.is_load;
  assign pipe.ex_is_store  = id_ex_q.ctrl.is_store;
  assign pipe.ex_is_branch = id_ex_q.ctrl.is_branch;
  assign pipe.ex_illegal   = id_ex_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic
// compared against an instruction-level model of the ID/EX register.
module tb_decode_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  rf_read_reg1, rf_read_reg2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_write_enable;
  logic [5:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;
  logic [31:0] regs [32];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_stage_if pipe ();

  decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .pipe            (pipe),
    .rf_read_reg1    (rf_read_reg1),
    .rf_read_reg2    (rf_read_reg2),
    .rf_read_data1   (rf_read_data1),
    .rf_read_data2   (rf_read_data2),
    .wb_write_enable (wb_write_enable),
    .wb_write_reg    (wb_write_reg),
    .wb_write_data   (wb_write_data),
    .flush           (flush)
  );

  // Register file model: old value visible during a write cycle.
  assign rf_read_data1 = regs[rf_read_reg1[4:0]];
  assign rf_read_data2 = regs[rf_read_reg2[4:0]];

  typedef struct {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [5:0]  rs1, rs2, rd;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        rw, ld, st, br, ill;
  } exp_t;

  exp_t m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] d1, input logic [31:0] d2);
    exp_t e = '{default: '0};
    e.valid = 1'b1;
    e.pc  = pc;
    e.d1  = d1;
    e.d2  = d2;
    e.rs1 = {1'b0, ins[19:15]};
    e.rs2 = {1'b0, ins[24:20]};
    e.rd  = {1'b0, ins[11:7]};
    e.opc = ins[6:0];
    e.f3  = ins[14:12];
    e.f7  = ins[31:25];
    case (ins[6:0])
      7'h33: e.rw = 1'b1;
      7'h13, 7'h67: begin e.rw = 1'b1; e.imm = 32'($signed(ins[31:20])); end
      7'h03: begin e.rw = 1'b1; e.ld = 1'b1; e.imm = 32'($signed(ins[31:20])); end
      7'h23: begin e.st = 1'b1; e.imm = 32'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin
        e.br  = 1'b1;
        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin e.rw = 1'b1; e.imm = {ins[31:12], 12'h000}; end
      7'h6F: begin
        e.rw  = 1'b1;
        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      default: e.ill = 1'b1;
    endcase
    if (ins[11:7] == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic check_ex();
    check("ex_valid", pipe.ex_valid, m.valid);
    if (m.valid) begin
      check("ex_pc", pipe.ex_pc, m.pc);
      check("ex_rs1_data", pipe.ex_rs1_data, m.d1);
      check("ex_rs2_data", pipe.ex_rs2_data, m.d2);
      check("ex_rs1", pipe.ex_rs1, m.rs1);
      check("ex_rs2", pipe.ex_rs2, m.rs2);
      check("ex_rd", pipe.ex_rd, m.rd);
      check("ex_opcode", pipe.ex_opcode, m.opc);
      check("ex_funct3", pipe.ex_funct3, m.f3);
      check("ex_funct7", pipe.ex_funct7, m.f7);
      check("ex_reg_write", pipe.ex_reg_write, m.rw);
      check("ex_is_load", pipe.ex_is_load, m.ld);
      check("ex_is_store", pipe.ex_is_store, m.st);
      check("ex_is_branch", pipe.ex_is_branch, m.br);
      check("ex_illegal", pipe.ex_illegal, m.ill);
      if (!m.ill) check("ex_imm", pipe.ex_imm, m.imm);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_if_ready"}, pipe.if_ready, 0);
    check({tag, "_ex_valid"}, pipe.ex_valid, 0);
    check({tag, "_ex_pc"}, pipe.ex_pc, 0);
    check({tag, "_ex_rs1_data"}, pipe.ex_rs1_data, 0);
    check({tag, "_ex_rs2_data"}, pipe.ex_rs2_data, 0);
    check({tag, "_ex_imm"}, pipe.ex_imm, 0);
    check({tag, "_ex_regs"}, {pipe.ex_rs1, pipe.ex_rs2, pipe.ex_rd}, 0);
    check({tag, "_ex_fields"}, {pipe.ex_opcode, pipe.ex_funct3, pipe.ex_funct7}, 0);
    check({tag, "_ex_ctrl"}, {pipe.ex_reg_write, pipe.ex_is_load, pipe.ex_is_store,
                              pipe.ex_is_branch, pipe.ex_illegal}, 0);
  endtask

  // One clock: drive after the falling edge, check if_ready before the rising
  // edge, advance the model, then check ID/EX after the next falling edge.
  task automatic cycle(input logic [31:0] instr, input logic v, input logic er, input logic fl,
                       input logic we, input logic [5:0] wr, input logic [31:0] wd);
    logic [4:0]  r1, r2;
    logic [6:0]  opc;
    logic        use1, use2, hit1, hit2, hz, rdy;
    logic [31:0] d1, d2, pc;
    exp_t        nxt;
    pc = 32'h1000 + {$urandom_range(0, 255), 2'b00};
    pipe.if_instr   = instr;
    pipe.if_pc      = pc;
    pipe.if_valid   = v;
    pipe.ex_ready   = er;
    flush           = fl;
    wb_write_enable = we;
    wb_write_reg    = wr;
    wb_write_data   = wd;
    #1;
    r1   = instr[19:15];
    r2   = instr[24:20];
    opc  = instr[6:0];
    use1 = !(opc inside {7'h37, 7'h17, 7'h6F});
    use2 = opc inside {7'h33, 7'h23, 7'h63};
    hit1 = we && wr == {1'b0, r1} && r1 != 0;
    hit2 = we && wr == {1'b0, r2} && r2 != 0;
    hz   = m.valid && m.ld && m.rd != 0 &&
           ((use1 && m.rd == {1'b0, r1}) || (use2 && m.rd == {1'b0, r2}));
`ifdef DECODE_WB_BYPASS_EN
    d1 = (r1 == 0) ? 32'h0 : (hit1 ? wd : regs[r1]);
    d2 = (r2 == 0) ? 32'h0 : (hit2 ? wd : regs[r2]);
`else
    hz = hz || (use1 && hit1) || (use2 && hit2);
    d1 = (r1 == 0) ? 32'h0 : regs[r1];
    d2 = (r2 == 0) ? 32'h0 : regs[r2];
`endif
    rdy = (!m.valid || er) && !hz && !fl;
    check("if_ready", pipe.if_ready, rdy);
    check("rf_read_reg1", rf_read_reg1, {1'b0, r1});
    check("rf_read_reg2", rf_read_reg2, {1'b0, r2});
    nxt = m;
    if (fl) nxt.valid = 1'b0;
    else if (v && rdy) nxt = model_decode(instr, pc, d1, d2);
    else if (er) nxt.valid = 1'b0;
    @(posedge clk);
    m = nxt;
    @(negedge clk);
    if (we && wr[4:0] != 0) regs[wr[4:0]] = wd;
    check_ex();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 check_reset_state("mid_reset");
    m = '{default: '0};
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  opcs [10];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03};
    ins = $urandom;
    if ($urandom_range(0, 15) == 0) return ins;
    ins[6:0]   = opcs[$urandom_range(0, 9)];
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    ins[11:7]  = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hBAD0BAD0;  // x0 must read as zero no matter what the RF returns
    regs[5] = 32'h12345678;
    m = '{default: '0};
    reset = 1'b1;
    pipe.if_valid = 1'b0; pipe.if_instr = '0; pipe.if_pc = '0; pipe.ex_ready = 1'b0;
    flush = 1'b0; wb_write_enable = 1'b0; wb_write_reg = '0; wb_write_data = '0;
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // addi x1,x0,5
    cycle(32'h00500093, 1, 1, 0, 0, 0, 0);
    check("addi_imm", pipe.ex_imm, 5);
    check("addi_rd", pipe.ex_rd, 1);
    check("addi_reg_write", pipe.ex_reg_write, 1);
    check("addi_rs1_data", pipe.ex_rs1_data, 0);
    // beq x0,x0,-4
    cycle(32'hFE000EE3, 1, 1, 0, 0, 0, 0);
    check("beq_imm", pipe.ex_imm, 32'hFFFFFFFC);
    check("beq_is_branch", pipe.ex_is_branch, 1);
    check("beq_reg_write", pipe.ex_reg_write, 0);

    // lw x2,0(x1) then add x3,x2,x2: one bubble
    cycle(32'h0000A103, 1, 1, 0, 0, 0, 0);
    cycle(32'h002101B3, 1, 1, 0, 0, 0, 0);
    check("load_use_bubble", pipe.ex_valid, 0);
    cycle(32'h002101B3, 1, 1, 0, 0, 0, 0);
    check("load_use_captured", pipe.ex_rd, 3);

    // add x6,x5,x0 while writeback writes x5
    cycle(32'h00028333, 1, 1, 0, 1, 6'd5, 32'hDEADBEEF);
`ifndef DECODE_WB_BYPASS_EN
    check("wb_stall_bubble", pipe.ex_valid, 0);
    cycle(32'h00028333, 1, 1, 0, 0, 0, 0);
`endif
    check("wb_rs1_data", pipe.ex_rs1_data, 32'hDEADBEEF);
    check("wb_rd", pipe.ex_rd, 6);

    // backpressure: addi x1,x0,5 held while addi x2,x0,1 waits
    cycle(32'h00500093, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(32'h00100113, 1, 0, 0, 0, 0, 0);
      check("stall_imm_held", pipe.ex_imm, 5);
    end
    cycle(32'h00100113, 1, 1, 0, 0, 0, 0);
    check("stall_release_imm", pipe.ex_imm, 1);

    // flush with an incoming instruction
    cycle(32'h00500093, 1, 0, 1, 0, 0, 0);
    check("flush_valid", pipe.ex_valid, 0);
    // illegal word
    cycle(32'hFFFFFFFF, 1, 1, 0, 0, 0, 0);
    check("illegal_flag", pipe.ex_illegal, 1);
    check("illegal_reg_write", pipe.ex_reg_write, 0);

    // randomized traffic with a reset pulse in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulse_reset();
      else cycle(rand_instr(), $urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                 6'($urandom_range(0, 3)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
